alu_muldiv: RTL and testbench

Iterative multiply/divide unit, parametrised in `WIDTH`, that extends the pCPU execute stage with the RV32M operations the single-cycle ALU cannot perform. The execute stage issues operands with a one-cycle `start` pulse. The unit computes in a radix-2 shift-add or shift-subtract datapath and returns the result with a one-cycle `done` pulse. The pipeline stalls on `busy` and can abort an in-flight operation with `kill` on a flush.

---
 rtl/alu_muldiv.sv | 179 +++++++++++++++++
 tb/tb_alu_muldiv.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// One operation in flight; result returned with a single-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for start; busy low
// CALC   | one shift-add / shift-subtract step per cycle, WIDTH steps
// FIX    | sign correction, result select, y/done registered
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   y_q, y_d;

  logic               a_sgn, b_sgn, a_neg, b_neg, b_zero, div_ovf;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res;

  // operand conditioning at the accepting edge
  always_comb begin
    a_sgn   = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_sgn   = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg   = a_sgn && a[WIDTH-1];
    b_neg   = b_sgn && b[WIDTH-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    b_zero  = (b == '0);
    div_ovf = ((op == 3'b100) || (op == 3'b110)) && (a == MIN_INT) && (b == '1);
  end

  // acc holds {product hi, multiplier/product lo} for multiply, {remainder, quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_diff[WIDTH]) begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      3'b000:                 res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: res = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         res = quo_fix;
      default:                res = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    y_d       = y_q;

    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          op_d      = op;
          cnt_d     = CNT_INIT;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          state_d   = S_CALC;
          if (op[2]) begin
            opnd_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
          end
          // special cases preset {remainder, quotient} and skip the iteration
          if (op[2] && b_zero) begin
            state_d   = S_FIX;
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
            acc_d     = {a, {WIDTH{1'b1}}};
          end else if (div_ovf) begin
            state_d   = S_FIX;
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
            acc_d     = {{WIDTH{1'b0}}, MIN_INT};
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        y_d     = res;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (kill) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      y_d     = y_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      y_q       <= y_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv at WIDTH=32 (dut index 0) and WIDTH=8 (dut index 1),
// checked each cycle against a transaction-level arithmetic model.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i [2];
  logic        kill_i  [2];
  logic [2:0]  op_i    [2];
  logic [31:0] a_i     [2];
  logic [31:0] b_i     [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic [31:0] y32;
  logic [7:0]  y8;

  int n_vec = 0;
  int n_err = 0;

  bit          m_busy [2] = '{0, 0};
  bit          m_done [2] = '{0, 0};
  int          m_left [2] = '{0, 0};
  logic [31:0] m_res  [2] = '{0, 0};
  logic [31:0] m_y    [2] = '{0, 0};

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start_i[0]), .kill(kill_i[0]), .op(op_i[0]),
    .a(a_i[0]), .b(b_i[0]), .busy(busy_o[0]), .done(done_o[0]), .y(y32)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_i[1]), .kill(kill_i[1]), .op(op_i[1]),
    .a(a_i[1][7:0]), .b(b_i[1][7:0]), .busy(busy_o[1]), .done(done_o[1]), .y(y8)
  );

  function automatic int wd(int k);
    return (k == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] mask_of(int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] y_of(int k);
    return (k == 0) ? y32 : {24'h0, y8};
  endfunction

  // RV32M semantics from plain wide signed arithmetic
  function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b, int w);
    logic [31:0] m;
    logic signed [127:0] ua, ub, sa, sb, r;
    m  = mask_of(w);
    ua = 128'(a & m);
    ub = 128'(b & m);
    sa = ua[w-1] ? ua - (128'sd1 <<< w) : ua;
    sb = ub[w-1] ? ub - (128'sd1 <<< w) : ub;
    case (op)
      3'd0, 3'd1: r = sa * sb;
      3'd2:       r = sa * ub;
      3'd3:       r = ua * ub;
      3'd4:       r = (ub == 0) ? -128'sd1 : sa / sb;
      3'd5:       r = (ub == 0) ? -128'sd1 : ua / ub;
      3'd6:       r = (ub == 0) ? ua : sa % sb;
      default:    r = (ub == 0) ? ua : ua % ub;
    endcase
    if (op == 3'd1 || op == 3'd2 || op == 3'd3) r = r >>> w;
    return r[31:0] & m;
  endfunction

  function automatic int lat_of(logic [2:0] op, logic [31:0] a, logic [31:0] b, int w);
    logic [31:0] m, msb;
    m   = mask_of(w);
    msb = 32'h1 << (w - 1);
    if (op[2] && ((b & m) == 32'h0)) return 1;
    if ((op == 3'b100 || op == 3'b110) && ((a & m) == msb) && ((b & m) == m)) return 1;
    return w + 1;
  endfunction

  function automatic logic [31:0] rnd_opnd(int w);
    logic [31:0] m;
    m = mask_of(w);
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return m;
      3:       return 32'h1 << (w - 1);
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom & m;
    endcase
  endfunction

  task automatic cmp(string nm, int k, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h, want %h", nm, k, got, exp);
    end
  endtask

  // reference model: advances on each clock edge, clears on reset
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_busy[k] = 0; m_done[k] = 0; m_left[k] = 0; m_res[k] = 0; m_y[k] = 0;
        end else begin
          m_done[k] = 0;
          if (m_busy[k]) begin
            if (kill_i[k]) begin
              m_busy[k] = 0;
            end else begin
              m_left[k]--;
              if (m_left[k] == 0) begin
                m_busy[k] = 0;
                m_done[k] = 1;
                m_y[k]    = m_res[k];
              end
            end
          end else if (start_i[k] && !kill_i[k]) begin
            m_busy[k] = 1;
            m_res[k]  = model(op_i[k], a_i[k], b_i[k], wd(k));
            m_left[k] = lat_of(op_i[k], a_i[k], b_i[k], wd(k));
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        cmp("busy", k, 32'(busy_o[k]), 32'(m_busy[k]));
        cmp("done", k, 32'(done_o[k]), 32'(m_done[k]));
        cmp("y", k, y_of(k), m_y[k]);
      end
    end
  end

  task automatic wait_idle(int k);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (busy_o[k] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) cmp("idle_timeout", k, 32'(busy_o[k]), 32'h0);
  endtask

  task automatic issue(int k, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    start_i[k] = 1'b1; op_i[k] = op; a_i[k] = a; b_i[k] = b;
    @(posedge clk); #1;
    start_i[k] = 1'b0;
  endtask

  // called just after the accepting edge; counts edges until done is seen
  task automatic wait_done(int k, output int lat);
    bit got;
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      @(posedge clk); @(negedge clk);
      lat++;
      got = done_o[k];
    end
  endtask

  task automatic run_lit(int k, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] exp_y, int exp_lat, string nm);
    int lat;
    wait_idle(k);
    issue(k, op, a, b);
    wait_done(k, lat);
    cmp({nm, "_lat"}, k, 32'(lat), 32'(exp_lat));
    cmp({nm, "_y"}, k, y_of(k), exp_y);
  endtask

  initial begin
    #600000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int nd, lat;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_i[k] = 0; kill_i[k] = 0; op_i[k] = 0; a_i[k] = 0; b_i[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_lit(0, 3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    run_lit(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    run_lit(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run_lit(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    run_lit(0, 3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, "div");
    run_lit(0, 3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, "rem");
    run_lit(0, 3'b101, 32'd100,      32'd7,         32'd14,        33, "divu");
    run_lit(0, 3'b111, 32'd100,      32'd7,         32'd2,         33, "remu");
    run_lit(0, 3'b101, 32'd5,        32'd0,         32'hFFFF_FFFF, 1,  "divu0");
    run_lit(0, 3'b111, 32'd5,        32'd0,         32'd5,         1,  "remu0");
    run_lit(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "divovf");
    run_lit(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        1,  "removf");

    // start pulses while busy are ignored
    wait_idle(0);
    issue(0, 3'b000, 32'd5, 32'd6);
    op_i[0] = 3'b000; a_i[0] = 32'd9; b_i[0] = 32'd9;
    nd = 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      start_i[0] = (i == 4 || i == 9);
      if (done_o[0]) nd++;
    end
    start_i[0] = 0;
    cmp("ignored_dones", 0, 32'(nd), 32'd1);
    cmp("ignored_y", 0, y32, 32'd30);

    // start in the same cycle as done is accepted
    wait_idle(0);
    issue(0, 3'b000, 32'd2, 32'd3);
    repeat (33) @(posedge clk);
    #1;
    cmp("done_at_33", 0, 32'(done_o[0]), 32'd1);
    cmp("done_at_33_y", 0, y32, 32'd6);
    issue(0, 3'b000, 32'd3, 32'd3);
    wait_done(0, lat);
    cmp("b2b_lat", 0, 32'(lat), 32'd33);
    cmp("b2b_y", 0, y32, 32'd9);

    // kill mid-divide
    wait_idle(0);
    issue(0, 3'b101, 32'd100, 32'd7);
    repeat (8) @(posedge clk);
    #1 kill_i[0] = 1;
    @(posedge clk); #1 kill_i[0] = 0;
    cmp("kill_busy", 0, 32'(busy_o[0]), 32'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_o[0]) nd++;
    end
    cmp("kill_dones", 0, 32'(nd), 32'd0);
    cmp("kill_y", 0, y32, 32'd9);
    run_lit(0, 3'b000, 32'd3, 32'd4, 32'd12, 33, "mul_after_kill");

    // kill and start together in IDLE: start dropped
    wait_idle(0);
    start_i[0] = 1; kill_i[0] = 1; op_i[0] = 3'b000;
    @(posedge clk); #1;
    start_i[0] = 0; kill_i[0] = 0;
    cmp("kill_start_busy", 0, 32'(busy_o[0]), 32'd0);

    // randomized traffic on both widths
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        start_i[k] = ($urandom_range(0, 3) == 0);
        kill_i[k]  = ($urandom_range(0, 99) == 0);
        op_i[k]    = 3'($urandom_range(0, 7));
        a_i[k]     = rnd_opnd(wd(k));
        b_i[k]     = rnd_opnd(wd(k));
      end
    end
    for (int k = 0; k < 2; k++) begin
      start_i[k] = 0; kill_i[k] = 0;
    end

    run_lit(0, 3'b000, 32'd3,  32'd4,  32'd12,  33, "mul_pre_rst");
    run_lit(1, 3'b011, 32'hFF, 32'hFF, 32'hFE,  9,  "mulhu8");

    // asynchronous reset mid-CALC on both units
    wait_idle(0);
    for (int k = 0; k < 2; k++) begin
      start_i[k] = 1; op_i[k] = 3'b011; a_i[k] = 32'hFF; b_i[k] = 32'hFF;
    end
    @(posedge clk); #1;
    start_i[0] = 0; start_i[1] = 0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      cmp("arst_busy", k, 32'(busy_o[k]), 32'd0);
      cmp("arst_done", k, 32'(done_o[k]), 32'd0);
      cmp("arst_y", k, y_of(k), 32'd0);
    end
    #1 rst = 1'b0;

    run_lit(1, 3'b011, 32'hFF, 32'hFF, 32'hFE, 9, "mulhu8_post_rst");
    run_lit(1, 3'b100, 32'h80, 32'hFF, 32'h80, 1, "div8ovf");
    run_lit(0, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_post_rst");

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
